// File: rtl/memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// memory_port_arbiter
//
// Purpose:
//   Shares one 32-bit unified memory port between the instruction fetch unit
//   (IF, read-only) and the data memory controller (D, read/write with byte
//   enables). A three-state grant FSM gives D fixed priority. A starvation
//   counter lets IF win after STARVE_MAX consecutive D grants taken while it
//   was waiting. A grant is held until the memory acknowledges it, and that
//   ack is routed only to the granted requester.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   IF_Address/ReadEnable    fetch request (level); IF_Ack is the done pulse
//   D_Address/WriteData/
//   D_ByteEnable/
//   D_ReadEnable/WriteEnable data request (level); D_Ack is the done pulse
//   ReadData                 Mem_ReadData passed through to both requesters
//   Mem_*                    memory-side port; Mem_Ack is the done pulse
//   Grant_IF, Grant_D        status: FSM currently serving IF / D
//
// Parameters:
//   STARVE_MAX  D grants allowed while IF waits before IF wins (1..15)
//   CNT_W       starvation counter width, must be able to hold STARVE_MAX
// ---------------------------------------------------------------------------
module memory_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        RST,
    // instruction fetch requester
    input  logic [31:0] IF_Address,
    input  logic        IF_ReadEnable,
    output logic        IF_Ack,
    // data requester
    input  logic [31:0] D_Address,
    input  logic [31:0] D_WriteData,
    input  logic [3:0]  D_ByteEnable,
    input  logic        D_ReadEnable,
    input  logic        D_WriteEnable,
    output logic        D_Ack,
    // shared read data
    output logic [31:0] ReadData,
    // memory side
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    output logic [3:0]  Mem_ByteEnable,
    output logic        Mem_ReadEnable,
    output logic        Mem_WriteEnable,
    input  logic [31:0] Mem_ReadData,
    input  logic        Mem_Ack,
    // status
    output logic        Grant_IF,
    output logic        Grant_D
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SERVE_D  = 2'd1;
    localparam logic [1:0] S_SERVE_IF = 2'd2;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic d_req;
    logic if_forced;

    assign d_req = D_ReadEnable | D_WriteEnable;

    // IF has been passed over often enough: it wins the next arbitration
    // even against a pending D request.
    assign if_forced = IF_ReadEnable & (cnt_q >= STARVE_LIM);

    // -----------------------------------------------------------------------
    // Next-state and starvation counter
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (d_req && !if_forced) begin
                    state_d = S_SERVE_D;
                    // Count only D grants that made a waiting IF wait longer;
                    // a D grant with nobody waiting starts the window afresh.
                    if (IF_ReadEnable) begin
                        cnt_d = (cnt_q >= STARVE_LIM) ? STARVE_LIM
                                                      : cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else if (IF_ReadEnable) begin
                    state_d = S_SERVE_IF;
                    cnt_d   = '0;
                end
            end
            S_SERVE_D: begin
                if (Mem_Ack) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVE_IF: begin
                if (Mem_Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output steering
    //
    // Outputs are gated by RST as well as by the state so that the memory
    // port goes quiet in the very cycle reset is applied, even if the FSM
    // register still holds a serving state until the next edge.
    // -----------------------------------------------------------------------
    always_comb begin
        Mem_Address     = '0;
        Mem_WriteData   = '0;
        Mem_ByteEnable  = '0;
        Mem_ReadEnable  = 1'b0;
        Mem_WriteEnable = 1'b0;
        IF_Ack          = 1'b0;
        D_Ack           = 1'b0;
        Grant_IF        = 1'b0;
        Grant_D         = 1'b0;
        if (!RST) begin
            case (state_q)
                S_SERVE_D: begin
                    Grant_D         = 1'b1;
                    Mem_Address     = D_Address;
                    Mem_WriteData   = D_WriteData;
                    Mem_ByteEnable  = D_WriteEnable ? D_ByteEnable : 4'b0000;
                    Mem_WriteEnable = D_WriteEnable;
                    // Read and write both requested is treated as a write.
                    Mem_ReadEnable  = D_ReadEnable & ~D_WriteEnable;
                    D_Ack           = Mem_Ack;
                end
                S_SERVE_IF: begin
                    Grant_IF       = 1'b1;
                    Mem_Address    = IF_Address;
                    Mem_ReadEnable = 1'b1;
                    IF_Ack         = Mem_Ack;
                end
                default: begin
                    // IDLE: a stray Mem_Ack is dropped here.
                end
            endcase
        end
    end

    assign ReadData = Mem_ReadData;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_port_arbiter
//
// Randomized bench: behavioural IF/D requesters and a random-latency memory
// drive the arbiter; a reference model that thinks in terms of "who owns the
// memory port" and "how many times IF has been passed over" predicts every
// output each cycle. Inputs change on the falling edge, outputs are sampled
// 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_memory_port_arbiter;

    localparam int STARVE = 4;

    localparam int OWN_NONE = 0;
    localparam int OWN_D    = 1;
    localparam int OWN_IF   = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IF_Address;
    logic        IF_ReadEnable;
    logic        IF_Ack;
    logic [31:0] D_Address;
    logic [31:0] D_WriteData;
    logic [3:0]  D_ByteEnable;
    logic        D_ReadEnable;
    logic        D_WriteEnable;
    logic        D_Ack;
    logic [31:0] ReadData;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic [3:0]  Mem_ByteEnable;
    logic        Mem_ReadEnable;
    logic        Mem_WriteEnable;
    logic [31:0] Mem_ReadData;
    logic        Mem_Ack;
    logic        Grant_IF;
    logic        Grant_D;

    always #5 CLK = ~CLK;

    memory_port_arbiter #(
        .STARVE_MAX(STARVE),
        .CNT_W     (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IF_Address     (IF_Address),
        .IF_ReadEnable  (IF_ReadEnable),
        .IF_Ack         (IF_Ack),
        .D_Address      (D_Address),
        .D_WriteData    (D_WriteData),
        .D_ByteEnable   (D_ByteEnable),
        .D_ReadEnable   (D_ReadEnable),
        .D_WriteEnable  (D_WriteEnable),
        .D_Ack          (D_Ack),
        .ReadData       (ReadData),
        .Mem_Address    (Mem_Address),
        .Mem_WriteData  (Mem_WriteData),
        .Mem_ByteEnable (Mem_ByteEnable),
        .Mem_ReadEnable (Mem_ReadEnable),
        .Mem_WriteEnable(Mem_WriteEnable),
        .Mem_ReadData   (Mem_ReadData),
        .Mem_Ack        (Mem_Ack),
        .Grant_IF       (Grant_IF),
        .Grant_D        (Grant_D)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model state ----------------
    int owner       = OWN_NONE; // who holds the memory port
    int passed_over = 0;        // D grants IF has sat through since it last won
    int if_wait     = 0;        // independent tally for the starvation bound

    // ---------------- stimulus knobs ----------------
    int p_if, p_d, p_ack, p_stray, p_rst;
    bit if_acked = 1'b0;
    bit d_acked  = 1'b0;
    int n_if_tx  = 0;
    int n_d_tx   = 0;

    task automatic drive_inputs();
        RST          = ($urandom_range(999) < p_rst);
        Mem_ReadData = $urandom;
        // IF requester: drops the cycle after its ack, otherwise may start.
        if (RST) begin
            IF_ReadEnable = 1'b0;
            if_acked      = 1'b0;
        end else if (if_acked) begin
            IF_ReadEnable = 1'b0;
            if_acked      = 1'b0;
        end else if (!IF_ReadEnable && $urandom_range(99) < p_if) begin
            IF_ReadEnable = 1'b1;
            IF_Address    = $urandom & 32'hFFFF_FFFC;
        end
        // D requester: read, write, or both (treated as write).
        if (RST) begin
            D_ReadEnable  = 1'b0;
            D_WriteEnable = 1'b0;
            d_acked       = 1'b0;
        end else if (d_acked) begin
            D_ReadEnable  = 1'b0;
            D_WriteEnable = 1'b0;
            d_acked       = 1'b0;
        end else if (!(D_ReadEnable || D_WriteEnable) && $urandom_range(99) < p_d) begin
            case ($urandom_range(2))
                0:       begin D_ReadEnable = 1'b1; D_WriteEnable = 1'b0; end
                1:       begin D_ReadEnable = 1'b0; D_WriteEnable = 1'b1; end
                default: begin D_ReadEnable = 1'b1; D_WriteEnable = 1'b1; end
            endcase
            D_Address    = $urandom;
            D_WriteData  = $urandom;
            D_ByteEnable = 4'($urandom_range(15));
        end
        // Memory: acks a live grant at random, occasionally acks for nothing.
        if (owner != OWN_NONE) Mem_Ack = ($urandom_range(99) < p_ack);
        else                   Mem_Ack = ($urandom_range(99) < p_stray);
    endtask

    task automatic check_outputs();
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_re, e_we, e_ifa, e_da, e_gif, e_gd;
        e_addr = '0; e_wd = '0; e_be = '0;
        e_re = 0; e_we = 0; e_ifa = 0; e_da = 0; e_gif = 0; e_gd = 0;
        if (!RST && owner == OWN_D) begin
            e_gd   = 1;
            e_addr = D_Address;
            e_wd   = D_WriteData;
            e_we   = D_WriteEnable;
            e_be   = D_WriteEnable ? D_ByteEnable : 4'b0000;
            e_re   = D_ReadEnable && !D_WriteEnable;
            e_da   = Mem_Ack;
        end else if (!RST && owner == OWN_IF) begin
            e_gif  = 1;
            e_addr = IF_Address;
            e_re   = 1;
            e_ifa  = Mem_Ack;
        end
        check("mem_addr",  Mem_Address,     e_addr);
        check("mem_wdata", Mem_WriteData,   e_wd);
        check("mem_be",    32'(Mem_ByteEnable), 32'(e_be));
        check("mem_re",    32'(Mem_ReadEnable), 32'(e_re));
        check("mem_we",    32'(Mem_WriteEnable), 32'(e_we));
        check("if_ack",    32'(IF_Ack),   32'(e_ifa));
        check("d_ack",     32'(D_Ack),    32'(e_da));
        check("grant_if",  32'(Grant_IF), 32'(e_gif));
        check("grant_d",   32'(Grant_D),  32'(e_gd));
        check("read_data", ReadData, Mem_ReadData);
        if (e_ifa) begin
            if_acked = 1'b1;
            n_if_tx++;
            $display("[%0t] IF read  addr=%h data=%h", $time, IF_Address, Mem_ReadData);
        end
        if (e_da) begin
            d_acked = 1'b1;
            n_d_tx++;
            $display("[%0t] D  %s addr=%h wdata=%h be=%b rdata=%h", $time,
                     D_WriteEnable ? "write" : "read ", D_Address, D_WriteData,
                     D_WriteEnable ? D_ByteEnable : 4'b0000, Mem_ReadData);
        end
    endtask

    // Advance the model across the rising edge.
    task automatic step_model();
        bit d_req;
        d_req = D_ReadEnable || D_WriteEnable;
        if (RST) begin
            owner       = OWN_NONE;
            passed_over = 0;
            if_wait     = 0;
        end else if (owner == OWN_NONE) begin
            if (d_req && !(IF_ReadEnable && passed_over >= STARVE)) begin
                owner = OWN_D;
                if (IF_ReadEnable) begin
                    passed_over = (passed_over + 1 > STARVE) ? STARVE : passed_over + 1;
                    if_wait++;
                end else begin
                    passed_over = 0;
                    if_wait     = 0;
                end
            end else if (IF_ReadEnable) begin
                owner = OWN_IF;
                check("if_wait_bound", 32'(if_wait <= STARVE), 32'd1);
                passed_over = 0;
                if_wait     = 0;
            end
        end else if (Mem_Ack) begin
            owner = OWN_NONE;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            drive_inputs();
            #1;
            check_outputs();
            step_model();
        end
    endtask

    initial begin
        RST = 1'b1;
        IF_Address = '0; IF_ReadEnable = 0;
        D_Address = '0; D_WriteData = '0; D_ByteEnable = '0;
        D_ReadEnable = 0; D_WriteEnable = 0;
        Mem_ReadData = '0; Mem_Ack = 0;

        // Reset held: everything quiet, stray acks dropped.
        p_if = 50; p_d = 50; p_ack = 50; p_stray = 50; p_rst = 1000;
        run_cycles(4);

        // Mixed random traffic with occasional mid-transaction resets.
        p_if = 30; p_d = 30; p_ack = 40; p_stray = 15; p_rst = 4;
        run_cycles(1500);

        // Saturated traffic, zero-wait memory: exercises starvation limit.
        p_if = 100; p_d = 100; p_ack = 100; p_stray = 0; p_rst = 0;
        run_cycles(300);

        // Slow memory, heavy D traffic, frequent resets.
        p_if = 60; p_d = 90; p_ack = 20; p_stray = 30; p_rst = 15;
        run_cycles(1200);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
